fir_decimator: RTL and testbench
================================

# fir_decimator

Downstream stage of `fir_filter`. Consumes the filter's signed 8-bit output stream on a per-sample strobe and performs integrate-and-dump decimation by 2^DECIM_LOG2, so each output is the block average of that many samples. Results are buffered in a small first-word-fall-through FIFO and presented on a valid/ready handshake to the next consumer, such as a capture or serialiser stage.

## Interface
- DECIM_LOG2, 2: log2 of the decimation factor; legal range 1..4, so the factor is 2..16.
- FIFO_LOG2, 2: log2 of the FIFO depth; legal range 1..4, so the depth is 2..16 entries.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_sig  input  8  signed sample from `fir_filter` `output_sig`.
- in_valid  input  1  one-cycle strobe meaning `in_sig` holds a new sample; driven from the filter's sample-update strobe.
- clr  input  1  synchronous clear of the phase counter, accumulator, FIFO and overflow flag.
- out_sig  output  8  signed decimated sample at the FIFO head.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts `out_sig` when `out_valid && out_ready`.
- fill  output  FIFO_LOG2+1  current FIFO occupancy, 0..2^FIFO_LOG2.
- overflow  output  1  sticky; set when a result is dropped.

## Operation
- Phase counter `phase` runs 0..2^DECIM_LOG2-1 and advances only on `in_valid`.
- Accumulator `acc` is signed, 8+DECIM_LOG2 bits wide, and cannot overflow.
  - On `in_valid` with `phase` below the maximum: `acc <= acc + in_sig`.
  - On `in_valid` with `phase` at the maximum (dump):
    - result = (acc + in_sig) >>> DECIM_LOG2, an arithmetic shift that truncates toward -infinity; the low 8 bits are pushed to the FIFO.
    - `acc <= 0` and `phase <= 0`.
- The result always fits in 8 bits because it is a mean of 8-bit values, so no saturation logic is required.
- FIFO:
  - Depth 2^FIFO_LOG2. Read and write pointers are FIFO_LOG2 bits wide and wrap modulo the depth. `fill` is a separate counter.
  - Push happens on a dump cycle. Pop happens when `out_valid && out_ready`.
  - Push when full is accepted only if a pop occurs in the same cycle; `fill` stays unchanged. Otherwise the result is discarded and `overflow <= 1`. The phase counter and accumulator still reset as usual.
  - Pop while empty is ignored.
  - Push and pop on the same cycle with `fill` equal to 0 is impossible, because pop requires `out_valid`.
- `out_sig` is the FIFO head, read combinationally from a registered storage array and read pointer. It holds its value when `out_valid` is 0. The head must not change while `out_valid && !out_ready`.
- `clr` behaviour:
  - Sets `phase`, `acc`, the pointers, `fill` and `overflow` to 0 on the next edge.
  - `clr` has priority over `in_valid` and over pop in the same cycle; the sample and the pop are both discarded.
- Reset (`rst_n` low), asynchronous:
  - `out_valid` = 0, `out_sig` = 0, `fill` = 0, `overflow` = 0.
  - `phase` = 0, `acc` = 0, pointers = 0.
  - FIFO storage is cleared so that `out_sig` reads 0.
  - A reset asserted mid-block discards the partial accumulation. The first `in_valid` after release is sample 0 of a new block.

## Timing
- Decimation latency: the dump `in_valid` is sampled on edge t. `out_valid` rises after edge t, with the new `out_sig`, if the FIFO was empty; this is one register stage.
- Throughput: one result per 2^DECIM_LOG2 `in_valid` strobes. Strobe spacing can be any value of 1 cycle or more, including back-to-back strobes.
- Pop: `out_valid && out_ready` at edge t. The next head, or `out_valid` = 0, is visible after edge t.
- `fill` and `overflow` are registered and update on the same edge as the push or pop that changes them.
- No combinational path from `out_ready` to `out_valid` or `out_sig`.

## Test plan
- Default parameters. `in_sig` = 10, 20, 30, 40 on four strobes spaced 20 cycles apart, `out_ready` = 1. Expect exactly one output, 25, with `out_valid` high for 1 cycle after the 4th strobe edge.
- Negative rounding: inputs -1, -1, -1, -2 give sum -5, and -5 >>> 2 = -2. Inputs 127 ×4 give 127. Inputs -128 ×4 give -128.
- Backpressure: `out_ready` = 0 while 20 samples of 1 are sent. Expect `fill` to go 1..4, then the 5th result dropped and `overflow` = 1. Raise `out_ready`; expect four outputs of 1, then `out_valid` = 0, with `overflow` still 1 until `clr`.
- Full with simultaneous pop: with `fill` = 4 and `out_ready` = 1 on the dump edge, expect `fill` to stay at 4, `overflow` to stay 0, and the new result to appear in the tail position.
- Mid-block reset: send 2 samples of 100, pulse `rst_n` low asynchronously between edges, then send 4 samples of 8. Expect all outputs 0 during reset and a single result of 8 afterwards.
- `clr` with a concurrent strobe: `clr` = 1 on the same cycle as a dump strobe. Expect no push, `phase` = 0, `fill` = 0, and the next four samples forming a fresh block.

Source files
------------

// File: rtl/fir_decimator.sv
// Integrate-and-dump decimator by 2^DECIM_LOG2 feeding a first-word-fall-through
// FIFO with a valid/ready output and a sticky overflow flag.
module fir_decimator #(
  parameter int DECIM_LOG2 = 2,
  parameter int FIFO_LOG2  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [7:0]       in_sig,
  input  logic                    in_valid,
  input  logic                    clr,
  output logic signed [7:0]       out_sig,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FIFO_LOG2:0]      fill,
  output logic                    overflow
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int AW    = 8 + DECIM_LOG2;
  localparam logic [FIFO_LOG2:0] FULL_COUNT = (FIFO_LOG2 + 1)'(DEPTH);

  logic [DECIM_LOG2-1:0] phase_reg, phase_next;
  logic signed [AW-1:0]  acc_reg, acc_next, sum;
  logic [FIFO_LOG2-1:0]  wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic [FIFO_LOG2:0]    fill_reg, fill_next;
  logic                  overflow_reg, overflow_next;
  logic                  dump, pop, push, full;
  logic [7:0]            result;
  logic [7:0]            mem_q [DEPTH];

  assign sum       = acc_reg + AW'(in_sig);
  assign dump      = in_valid && (phase_reg == '1);
  // Taking the bits above the shift is the arithmetic shift truncated to 8 bits.
  assign result    = sum[DECIM_LOG2 +: 8];
  assign full      = (fill_reg == FULL_COUNT);
  assign out_valid = (fill_reg != '0);
  assign pop       = out_valid && out_ready;
  assign push      = dump && (!full || pop);

  always_comb begin
    phase_next    = phase_reg;
    acc_next      = acc_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    fill_next     = fill_reg;
    overflow_next = overflow_reg;
    if (clr) begin
      phase_next    = '0;
      acc_next      = '0;
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      fill_next     = '0;
      overflow_next = 1'b0;
    end else begin
      if (in_valid) begin
        phase_next = phase_reg + 1'b1;
        acc_next   = dump ? '0 : sum;
      end
      if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      if (push && !pop)      fill_next = fill_reg + 1'b1;
      else if (pop && !push) fill_next = fill_reg - 1'b1;
      if (dump && !push) overflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg    <= '0;
      acc_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fill_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      phase_reg    <= phase_next;
      acc_reg      <= acc_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      fill_reg     <= fill_next;
      overflow_reg <= overflow_next;
    end
  end

  // Storage is reset so the head reads 0 straight out of reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    logic [7:0] entry_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        entry_reg <= '0;
      else if (!clr && push && (wr_ptr_reg == FIFO_LOG2'(gi)))
        entry_reg <= result;
    end
    assign mem_q[gi] = entry_reg;
  end

  assign out_sig  = mem_q[rd_ptr_reg];
  assign fill     = fill_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_fir_decimator.sv
// Bench for fir_decimator: table of four-sample blocks plus hand-written
// backpressure, full-with-pop, mid-block reset and clear sequences.
module tb_fir_decimator;

  logic              clk = 1'b0;
  logic              rst_n;
  logic signed [7:0] in_sig;
  logic              in_valid;
  logic              clr;
  logic signed [7:0] out_sig;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        fill;
  logic              overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int sb [$];

  typedef struct {
    int s [4];
    int exp;
  } vec_t;
  vec_t vecs [8];

  fir_decimator #(.DECIM_LOG2(2), .FIFO_LOG2(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_sig(in_sig), .in_valid(in_valid), .clr(clr),
    .out_sig(out_sig), .out_valid(out_valid), .out_ready(out_ready),
    .fill(fill), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Scoreboard: every accepted output is compared against the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        check("sb_out_sig", int'(out_sig), sb[0]);
        void'(sb.pop_front());
      end
    end
  end

  task automatic send_sample(input int v, input int gap);
    in_sig   = 8'(v);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_block(input int v, input int gap);
    for (int k = 0; k < 4; k++) send_sample(v, gap);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb.size() > 0; k++) begin @(posedge clk); #1; end
    check("drain_queue_empty", sb.size(), 0);
  endtask

  task automatic set_vec(input int i, input int a, input int b, input int c,
                         input int d, input int e);
    vecs[i].s[0] = a; vecs[i].s[1] = b; vecs[i].s[2] = c; vecs[i].s[3] = d;
    vecs[i].exp = e;
  endtask

  initial begin
    set_vec(0,   10,   20,   30,   40,   25);
    set_vec(1,   -1,   -1,   -1,   -2,   -2);
    set_vec(2,  127,  127,  127,  127,  127);
    set_vec(3, -128, -128, -128, -128, -128);
    set_vec(4,    1,    2,    3,    4,    2);
    set_vec(5,   -1,    0,    0,    0,   -1);
    set_vec(6,   -3,   -3,   -3,   -4,   -4);
    set_vec(7,  100, -100,   50,  -51,   -1);

    rst_n = 1'b0; in_sig = '0; in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sig",   int'(out_sig),   0);
    check("rst_fill",      int'(fill),      0);
    check("rst_overflow",  int'(overflow),  0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic block, strobes 20 cycles apart; output valid for exactly one cycle.
    sb.push_back(25);
    send_sample(10, 20); send_sample(20, 20); send_sample(30, 20);
    send_sample(40, 0);
    check("basic_out_valid", int'(out_valid), 1);
    check("basic_out_sig",   int'(out_sig),   25);
    @(posedge clk); #1;
    check("basic_valid_drop", int'(out_valid), 0);
    drain();

    for (int i = 0; i < 8; i++) begin
      sb.push_back(vecs[i].exp);
      for (int k = 0; k < 4; k++) send_sample(vecs[i].s[k], i % 3);
    end
    drain();

    // Backpressure: four results fill the FIFO, the fifth is dropped.
    out_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      sb.push_back(1);
      send_block(1, 1);
      check("bp_fill", int'(fill), b + 1);
      check("bp_no_overflow", int'(overflow), 0);
    end
    send_block(1, 1);
    check("bp_fill_full", int'(fill), 4);
    check("bp_overflow", int'(overflow), 1);
    out_ready = 1'b1;
    drain();
    check("bp_empty_after", int'(out_valid), 0);
    check("bp_overflow_sticky", int'(overflow), 1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("bp_overflow_cleared", int'(overflow), 0);

    // Full FIFO with a pop on the dump edge.
    out_ready = 1'b0;
    for (int v = 4; v < 8; v++) begin
      sb.push_back(v);
      send_block(v, 1);
    end
    check("fp_fill_full", int'(fill), 4);
    sb.push_back(9);
    for (int k = 0; k < 3; k++) send_sample(9, 1);
    in_sig = 8'sd9; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("fp_fill_stays", int'(fill), 4);
    check("fp_no_overflow", int'(overflow), 0);
    check("fp_new_head", int'(out_sig), 5);
    out_ready = 1'b1;
    drain();

    // Mid-block asynchronous reset.
    out_ready = 1'b0;
    send_block(50, 1);
    check("mr_head_before", int'(out_sig), 50);
    send_sample(100, 1); send_sample(100, 1);
    #3 rst_n = 1'b0;
    #1;
    check("mr_out_valid", int'(out_valid), 0);
    check("mr_out_sig",   int'(out_sig),   0);
    check("mr_fill",      int'(fill),      0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    sb.push_back(8);
    send_block(8, 1);
    drain();

    // Clear on the same cycle as a dump strobe.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send_sample(20, 1);
    in_sig = 8'sd20; in_valid = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; clr = 1'b0;
    check("clr_fill", int'(fill), 0);
    check("clr_out_valid", int'(out_valid), 0);
    sb.push_back(12);
    send_block(12, 0);
    check("clr_fresh_fill", int'(fill), 1);
    check("clr_fresh_sig", int'(out_sig), 12);
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
